// File: rtl/median_filter_pkg.sv
// ---------------------------------------------------------------------------
// median_filter_pkg
// Types and constants shared by the median filter datapath: the pixel width,
// the default image geometry, and the 3x3 window index map. Both the window
// generator and the 9-input median finder use this map.
//
// Window index map (row-major):
//   WIN_TL WIN_TC WIN_TR     row r-2 (oldest line)
//   WIN_ML WIN_MC WIN_MR     row r-1
//   WIN_BL WIN_BC WIN_BR     row r   (WIN_BR is the newest pixel)
// ---------------------------------------------------------------------------
package median_filter_pkg;

    localparam int PIXEL_W            = 8;
    localparam int DEFAULT_IMG_WIDTH  = 640;
    localparam int DEFAULT_IMG_HEIGHT = 480;

    localparam int WIN_ROWS = 3;
    localparam int WIN_COLS = 3;
    localparam int WIN_SIZE = WIN_ROWS * WIN_COLS;

    localparam int WIN_TL = 0;
    localparam int WIN_TC = 1;
    localparam int WIN_TR = 2;
    localparam int WIN_ML = 3;
    localparam int WIN_MC = 4;
    localparam int WIN_MR = 5;
    localparam int WIN_BL = 6;
    localparam int WIN_BC = 7;
    localparam int WIN_BR = 8;

endpackage

// File: rtl/line_buffer.sv
// ---------------------------------------------------------------------------
// line_buffer
// One image line of pixel storage. The read is combinational at addr, so a
// read-modify-write at the same address in one cycle returns the old value.
// The storage has no reset; its contents are don't-care until written.
//
// Ports:
//   clk      clock
//   wr_en    write wr_data into mem[addr] on the rising edge
//   addr     read and write address (pixel column)
//   wr_data  data to store
//   rd_data  current contents of mem[addr]
// ---------------------------------------------------------------------------
module line_buffer #(
    parameter int DEPTH   = 640,
    parameter int PIXEL_W = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [PIXEL_W-1:0]       wr_data,
    output logic [PIXEL_W-1:0]       rd_data
);

    logic [PIXEL_W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sliding_window_3x3.sv
// ---------------------------------------------------------------------------
// sliding_window_3x3
// Raster-to-window front end. Takes one pixel per accepted cycle in raster
// order, keeps the two previous lines in cascaded line buffers, and presents
// every fully interior 3x3 neighbourhood with a one-cycle valid strobe.
// Border windows are suppressed, so the output image is (W-2) x (H-2).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid            accept in_pixel / in_sof on this edge
//   in_sof              this pixel is (row 0, col 0); restarts the frame
//   in_pixel            raster pixel
//   out_valid           pixel0..8 hold a new interior window
//   pixel0..pixel8      window, row-major; pixel8 is the newest pixel
//   frame_done          pulse with the last window of a frame
// ---------------------------------------------------------------------------
module sliding_window_3x3
    import median_filter_pkg::*;
#(
    parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [PIXEL_W-1:0] in_pixel,
    output logic               out_valid,
    output logic [PIXEL_W-1:0] pixel0,
    output logic [PIXEL_W-1:0] pixel1,
    output logic [PIXEL_W-1:0] pixel2,
    output logic [PIXEL_W-1:0] pixel3,
    output logic [PIXEL_W-1:0] pixel4,
    output logic [PIXEL_W-1:0] pixel5,
    output logic [PIXEL_W-1:0] pixel6,
    output logic [PIXEL_W-1:0] pixel7,
    output logic [PIXEL_W-1:0] pixel8,
    output logic               frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(2);

    logic [COL_W-1:0] col_reg, col_next, pos_col;
    logic [ROW_W-1:0] row_reg, row_next, pos_row;
    logic             out_valid_reg, frame_done_reg;
    logic [PIXEL_W-1:0] lb0_q, lb1_q;
    logic [PIXEL_W-1:0] col_in [WIN_ROWS];
    logic [PIXEL_W-1:0] win    [WIN_SIZE];

    // in_sof overrides the counters, so a mid-frame sof simply restarts
    // counting and a sof at the natural (0,0) changes nothing.
    assign pos_col = in_sof ? '0 : col_reg;
    assign pos_row = in_sof ? '0 : row_reg;

    always_comb begin
        col_next = pos_col + 1'b1;
        row_next = pos_row;
        if (pos_col == COL_LAST) begin
            col_next = '0;
            row_next = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
        end
    end

    // lb0 holds line r-1; its old contents at this column shift into lb1,
    // which then holds line r-2.
    line_buffer #(.DEPTH(IMG_WIDTH), .PIXEL_W(PIXEL_W)) u_lb0 (
        .clk     (clk),
        .wr_en   (in_valid),
        .addr    (pos_col),
        .wr_data (in_pixel),
        .rd_data (lb0_q)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .PIXEL_W(PIXEL_W)) u_lb1 (
        .clk     (clk),
        .wr_en   (in_valid),
        .addr    (pos_col),
        .wr_data (lb0_q),
        .rd_data (lb1_q)
    );

    assign col_in[0] = lb1_q;
    assign col_in[1] = lb0_q;
    assign col_in[2] = in_pixel;

    // One shift register per window row: the new column enters on the right.
    genvar gi;
    generate
        for (gi = 0; gi < WIN_ROWS; gi++) begin : g_row
            logic [PIXEL_W-1:0] left_reg, mid_reg, right_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    left_reg  <= '0;
                    mid_reg   <= '0;
                    right_reg <= '0;
                end else if (in_valid) begin
                    left_reg  <= mid_reg;
                    mid_reg   <= right_reg;
                    right_reg <= col_in[gi];
                end
            end

            assign win[gi*WIN_COLS + 0] = left_reg;
            assign win[gi*WIN_COLS + 1] = mid_reg;
            assign win[gi*WIN_COLS + 2] = right_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg        <= '0;
            row_reg        <= '0;
            out_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            out_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            if (in_valid) begin
                col_reg        <= col_next;
                row_reg        <= row_next;
                // Gating on row/col >= 2 also hides stale line-buffer data
                // from a previous frame.
                out_valid_reg  <= (pos_row >= ROW_FIRST_WIN) && (pos_col >= COL_FIRST_WIN);
                frame_done_reg <= (pos_row == ROW_LAST) && (pos_col == COL_LAST);
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign frame_done = frame_done_reg;
    assign pixel0 = win[WIN_TL];
    assign pixel1 = win[WIN_TC];
    assign pixel2 = win[WIN_TR];
    assign pixel3 = win[WIN_ML];
    assign pixel4 = win[WIN_MC];
    assign pixel5 = win[WIN_MR];
    assign pixel6 = win[WIN_BL];
    assign pixel7 = win[WIN_BC];
    assign pixel8 = win[WIN_BR];

endmodule

// File: doc/sliding_window_3x3.md
# sliding_window_3x3

Raster-to-window front end for the median filter datapath. Accepts one 8-bit pixel per accepted cycle in row-major raster order, buffers the two previous image lines, and presents each fully-interior 3x3 neighbourhood as nine parallel pixels (pixel0..pixel8, row-major) with a valid strobe. It is the producer that feeds the 9-input median finder. Border windows are never emitted; the output image is (IMG_WIDTH-2) x (IMG_HEIGHT-2).

## Interface
- IMG_WIDTH, 640, pixels per line; must be at least 3.
- IMG_HEIGHT, 480, lines per frame; must be at least 3.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_pixel/in_sof accepted on this edge; no backpressure.
- in_sof  in  1  start of frame; qualified by in_valid; this pixel is (row 0, col 0).
- in_pixel  in  8  raster pixel.
- out_valid  out  1  pixel0..8 hold a new interior window this cycle.
- pixel0, pixel1, pixel2  out  8 each  window top row, left to right (row r-2).
- pixel3, pixel4, pixel5  out  8 each  middle row (row r-1).
- pixel6, pixel7, pixel8  out  8 each  bottom row (row r); pixel8 is the newest pixel.
- frame_done  out  1  one-cycle pulse coincident with the last window of a frame.

## Operation
- Counters: col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the position of the next pixel to be accepted. Widths are $clog2 of each dimension.
- Accept on in_valid=1. Position = (0,0) if in_sof=1, else (row,col).
- After accept, col increments. When col wraps to 0, row increments. When row wraps to 0, the frame has ended.
- Line buffers: lb0 holds line r-1 and lb1 holds line r-2. Each is IMG_WIDTH deep and addressed by col. Read is combinational and happens before the write.
- On accept at column c, each window row shifts left: column 0 takes column 1, column 1 takes column 2.
- New right column on accept: top = lb1[c], middle = lb0[c], bottom = in_pixel. In the same edge, lb1[c] takes lb0[c] and lb0[c] takes in_pixel.
- out_valid is set on an edge that accepts a pixel at row>=2 and col>=2; otherwise it is set to 0.
- frame_done is set on the edge that accepts (IMG_HEIGHT-1, IMG_WIDTH-1).
- Line buffers are not cleared between frames. Stale data is never exposed, because of the row>=2 / col>=2 gating.
- in_sof mid-frame: the current frame is abandoned with no frame_done. Counting restarts, and the first window is emitted at the new (2,2).
- in_sof on the natural (0,0) position is a no-op.
- in_sof with in_valid=0 is ignored.

## Timing
- Latency: 1 cycle. Outputs reflect the pixel accepted on the same rising edge and are visible for the following cycle.
- out_valid and frame_done are single-cycle per accepted pixel. When in_valid=0, both go to 0 on the next edge. pixel0..8 hold their values.
- Continuous input gives (IMG_WIDTH-2) consecutive valid cycles per interior line, followed by 2 invalid cycles at each line start.
- Reset (rst_n=0, async): out_valid=0, frame_done=0, pixel0..8=0, col=0, row=0. Line-buffer contents are don't-care.
- Reset mid-frame: the next accepted pixel is treated as (0,0).
- Throughput: one pixel per clock, sustained.

## Structure
- Shared package median_filter_pkg holds:
  - PIXEL_W = 8;
  - default IMG_WIDTH and IMG_HEIGHT;
  - the window-index constants used by both this block and the median finder.
- Sub-module line_buffer (parameters DEPTH and PIXEL_W): combinational read at addr, synchronous write at addr with wr_en. No reset on storage.
- Instantiate it twice, cascaded: lb0 output feeds lb1 input.
- Top level holds the counters, the 3x3 window registers and the valid/frame_done logic.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release, then feed pixels -> first out_valid only after the pixel at (2,2).
- IMG_WIDTH=5, IMG_HEIGHT=4, pixel = 10*row+col, continuous:
  - first window is 0,1,2,10,11,12,20,21,22;
  - exactly 6 windows;
  - last window is 12,13,14,22,23,24,32,33,34, with frame_done=1 on that cycle only.
- Same image with in_valid toggling 1/0 -> identical window sequence; out_valid never high in a cycle after in_valid=0.
- Two back-to-back 5x4 frames, second with values +100 -> first window of frame 2 is 100,101,102,110,111,112,120,121,122, with no frame-1 data in any frame-2 window.
- in_sof asserted at (2,3) of frame 1 -> no frame_done for frame 1; next windows start after the new (2,2) and contain only post-sof data.
- rst_n pulsed low for 1 cycle at (3,1) -> outputs 0 immediately; subsequent 5x4 frame produces the standard 6 windows.
